input_event_arbiter: RTL and testbench

Per-channel debouncer and event scheduler for already-synchronized board inputs such as buttons, switches and status lines. The inputs come from the two-flop synchronizer stage. Each channel filters glitches with a stability counter and latches a pending event on every accepted level change. A round-robin arbiter then serializes all pending events onto one valid/ready event stream for downstream control logic.

---
 rtl/input_event_arbiter.sv | 124 ++++++++++++
 tb/tb_input_event_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/input_event_arbiter.sv
// rtl/input_event_arbiter.sv - per-channel input debouncer with round-robin event serializer
module input_event_arbiter #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CH_W            = $clog2(NUM_CH),
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sync_in,
    output logic [NUM_CH-1:0] db_state,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_level,
    output logic [NUM_CH-1:0] evt_overflow,
    input  logic              ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] db_state_q, db_state_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] evt_overflow_q, evt_overflow_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic              evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
    logic              evt_level_q, evt_level_d;

    logic [NUM_CH-1:0] accept;
    logic              load;
    logic              found;
    logic [CH_W-1:0]   sel;
    logic [CH_W-1:0]   idx;
    int                idx_int;

    // Debounce: count consecutive cycles of disagreement, accept a new level after DEBOUNCE_CYCLES
    always_comb begin
        accept     = '0;
        db_state_d = db_state_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (sync_in[i] != db_state_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i]     = 1'b1;
                    db_state_d[i] = ~db_state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        idx     = '0;
        idx_int = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx_int = (int'(last_grant_q) + k) % NUM_CH;
            idx     = CH_W'(idx_int);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Output register load, pending bookkeeping and sticky overflow flags
    always_comb begin
        load           = !evt_valid_q || evt_ready;
        evt_valid_d    = evt_valid_q;
        evt_ch_d       = evt_ch_q;
        evt_level_d    = evt_level_q;
        last_grant_d   = last_grant_q;
        pending_d      = pending_q;
        evt_overflow_d = ovf_clr ? '0 : evt_overflow_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_ch_d       = sel;
                evt_level_d    = db_state_q[sel];
                last_grant_d   = sel;
                pending_d[sel] = 1'b0;
            end
        end
        // A newly accepted level always leaves the channel pending, even if it was just granted
        pending_d      = pending_d | accept;
        evt_overflow_d = evt_overflow_d | (accept & pending_q);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            db_state_q     <= '0;
            pending_q      <= '0;
            evt_overflow_q <= '0;
            last_grant_q   <= CH_W'(NUM_CH - 1);
            evt_valid_q    <= 1'b0;
            evt_ch_q       <= '0;
            evt_level_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            db_state_q     <= db_state_d;
            pending_q      <= pending_d;
            evt_overflow_q <= evt_overflow_d;
            last_grant_q   <= last_grant_d;
            evt_valid_q    <= evt_valid_d;
            evt_ch_q       <= evt_ch_d;
            evt_level_q    <= evt_level_d;
        end
    end

    assign db_state     = db_state_q;
    assign evt_valid    = evt_valid_q;
    assign evt_ch       = evt_ch_q;
    assign evt_level    = evt_level_q;
    assign evt_overflow = evt_overflow_q;

endmodule

// File: tb/tb_input_event_arbiter.sv
// tb/tb_input_event_arbiter.sv - scoreboard bench for input_event_arbiter
module tb_input_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int DB     = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] sync_in = '0;
    logic [NUM_CH-1:0] db_state;
    logic              evt_valid;
    logic              evt_ready = 1'b1;
    logic [CH_W-1:0]   evt_ch;
    logic              evt_level;
    logic [NUM_CH-1:0] evt_overflow;
    logic              ovf_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    logic [2:0] exp_q [$];

    input_event_arbiter #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .db_state(db_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .evt_level(evt_level), .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int ch, input bit lvl);
        logic [2:0] e;
        e = {CH_W'(ch), lvl};
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake pops one expected {ch, level}
    always begin
        @(negedge clk);
        #1;
        if (mon_en && rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_evt", {evt_ch, evt_level}, 3'h7);
            end else begin
                check("evt_payload", {29'd0, evt_ch, evt_level}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sync_in = '0;
        evt_ready = 1'b1;
        ovf_clr = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_db", db_state, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_ch", evt_ch, 0);
        check("rst_level", evt_level, 0);
        check("rst_ovf", evt_overflow, 0);
        mon_en = 1'b1;

        // 1: single rising input, latency
        sync_in = 4'b0100;
        push(2, 1);
        step(3);
        check("t1_db_e3", db_state, 4'b0000);
        step(1);
        check("t1_db_e4", db_state, 4'b0100);
        check("t1_valid_e4", evt_valid, 0);
        step(1);
        check("t1_valid_e5", evt_valid, 1);
        check("t1_ch_e5", evt_ch, 2);
        check("t1_lvl_e5", evt_level, 1);
        step(1);
        check("t1_valid_e6", evt_valid, 0);

        // 2: glitch rejection
        sync_in = 4'b0110;
        step(3);
        sync_in = 4'b0100;
        step(4);
        check("t2_db", db_state, 4'b0100);
        check("t2_valid", evt_valid, 0);
        check("t2_ovf", evt_overflow, 0);
        check("t2_q_empty", exp_q.size(), 0);

        // 3: round robin after reset
        do_reset();
        sync_in = 4'b1111;
        for (int c = 0; c < 4; c++) push(c, 1);
        step(4);
        for (int c = 0; c < 4; c++) begin
            step(1);
            check("t3_rr_ch", evt_ch, c);
        end
        step(1);
        check("t3_idle", evt_valid, 0);
        evt_ready = 1'b0;
        sync_in = 4'b1101;
        step(5);
        check("t3_ch1_held", {evt_valid, evt_ch}, {1'b1, 2'd1});
        sync_in = 4'b0000;
        push(1, 0); push(2, 0); push(3, 0); push(0, 0);
        step(5);
        evt_ready = 1'b1;
        step(6);
        check("t3_q_empty", exp_q.size(), 0);

        // 4: backpressure and overflow
        evt_ready = 1'b0;
        sync_in = 4'b0001;
        step(5);
        for (int i = 0; i < 20; i++) begin
            if (i == 0) sync_in = 4'b0101;
            if (i == 8) sync_in = 4'b0001;
            step(1);
            check("t4_hold", {evt_valid, evt_ch, evt_level}, {1'b1, 2'd0, 1'b1});
        end
        check("t4_ovf", evt_overflow, 4'b0100);
        check("t4_db", db_state, 4'b0001);
        push(0, 1); push(2, 0);
        evt_ready = 1'b1;
        step(4);
        check("t4_ovf_sticky", evt_overflow, 4'b0100);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", evt_overflow, 0);
        check("t4_q_empty", exp_q.size(), 0);

        // 5: grant and toggle on the same edge
        sync_in = 4'b0000;
        push(0, 0);
        step(6);
        evt_ready = 1'b0;
        sync_in = 4'b0011;
        step(5);
        check("t5_ch1_held", {evt_valid, evt_ch}, {1'b1, 2'd1});
        push(1, 1); push(0, 1); push(0, 0);
        sync_in = 4'b0010;
        step(3);
        evt_ready = 1'b1;
        step(4);
        check("t5_db", db_state, 4'b0010);
        check("t5_q_empty", exp_q.size(), 0);

        // 6: reset mid-operation
        evt_ready = 1'b0;
        sync_in = 4'b1101;
        step(5);
        check("t6_pre_valid", evt_valid, 1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", evt_valid, 0);
        check("t6_rst_db", db_state, 0);
        check("t6_rst_ch", evt_ch, 0);
        check("t6_rst_lvl", evt_level, 0);
        check("t6_rst_ovf", evt_overflow, 0);
        sync_in = '0;
        evt_ready = 1'b1;
        step(1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t6_no_evt", evt_valid, 0);
        end
        check("t6_db", db_state, 0);
        check("t6_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
